// File: rtl/match_req_arbiter_pkg.sv
// Shared widths for the match request arbiter, the job_pe requesters and the
// match unit, so all three agree on address, length and widened tag layout.
package match_req_arbiter_pkg;

  localparam int ADDR_WIDTH         = 16;
  localparam int MAX_MATCH_LEN_LOG2 = 5;
  localparam int LEN_WIDTH          = MAX_MATCH_LEN_LOG2 + 1;
  localparam int MATCH_TAG_WIDTH    = 8;
  localparam int MATCH_ARB_NUM_PE   = 4;
  localparam int MATCH_ARB_IDX_W    = $clog2(MATCH_ARB_NUM_PE);
  // Tag seen by the match unit: {pe_idx, local tag}
  localparam int MATCH_ARB_TAG_W    = MATCH_TAG_WIDTH + MATCH_ARB_IDX_W;

  // True when n is a power of two; decides whether a response index can be
  // out of range.
  function automatic bit is_pow2(input int n);
    return (n > 0) && ((n & (n - 1)) == 0);
  endfunction

endpackage

// File: rtl/match_req_arbiter_rr.sv
// Combinational round-robin picker: first set request bit at or above ptr,
// wrapping around. Produces a one-hot grant, its index and an any flag.
module match_req_arbiter_rr #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  grant_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);

  int j;

  // Scan N positions starting at the pointer; the first hit wins.
  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    any_o   = 1'b0;
    j       = 0;
    for (int off = 0; off < N; off++) begin
      j = (int'(ptr_i) + off) % N;
      if (!any_o && req_i[j]) begin
        any_o      = 1'b1;
        grant_o[j] = 1'b1;
        idx_o      = IW'(j);
      end
    end
  end

endmodule

// File: rtl/match_req_arbiter.sv
// Shares one match unit among NUM_PE requesters. Requests are round-robin
// arbitrated into a single registered downstream slot, tagged with the source
// PE index; responses are steered back by that index. A per-PE outstanding
// counter caps in-flight work so no requester can monopolise the unit.
//
// Handshake rule on every interface: a transfer happens on a rising clock
// edge where valid and ready are both high; valid never waits for ready, and
// a held request keeps its payload stable until it transfers.
module match_req_arbiter
  import match_req_arbiter_pkg::*;
#(
  parameter  int NUM_PE          = MATCH_ARB_NUM_PE,
  parameter  int MAX_OUTSTANDING = 4,
  localparam int PE_IDX_W        = $clog2(NUM_PE),
  localparam int TAG_W           = MATCH_TAG_WIDTH + PE_IDX_W,
  localparam int CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [NUM_PE-1:0]                 pe_req_valid,
  input  logic [NUM_PE*ADDR_WIDTH-1:0]      pe_req_head_addr,
  input  logic [NUM_PE*ADDR_WIDTH-1:0]      pe_req_history_addr,
  input  logic [NUM_PE*MATCH_TAG_WIDTH-1:0] pe_req_tag,
  output logic [NUM_PE-1:0]                 pe_req_ready,
  output logic [NUM_PE-1:0]                 pe_resp_valid,
  output logic [LEN_WIDTH-1:0]              pe_resp_len,
  output logic [MATCH_TAG_WIDTH-1:0]        pe_resp_tag,
  input  logic [NUM_PE-1:0]                 pe_resp_ready,
  output logic                              mu_req_valid,
  output logic [ADDR_WIDTH-1:0]             mu_req_head_addr,
  output logic [ADDR_WIDTH-1:0]             mu_req_history_addr,
  output logic [TAG_W-1:0]                  mu_req_tag,
  input  logic                              mu_req_ready,
  input  logic                              mu_resp_valid,
  input  logic [LEN_WIDTH-1:0]              mu_resp_len,
  input  logic [TAG_W-1:0]                  mu_resp_tag,
  output logic                              mu_resp_ready,
  output logic                              idle,
  output logic                              err
);

  // ---------------------------------------------------------------- state
  logic                    req_valid_q, req_valid_d;
  logic [ADDR_WIDTH-1:0]   head_q, head_d;
  logic [ADDR_WIDTH-1:0]   hist_q, hist_d;
  logic [TAG_W-1:0]        tag_q, tag_d;
  logic [PE_IDX_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]        cnt_q [NUM_PE];
  logic [CNT_W-1:0]        cnt_d [NUM_PE];
  logic                    err_q, err_d;

  // ---------------------------------------------------------------- arbitration
  logic [NUM_PE-1:0]   eligible;
  logic [NUM_PE-1:0]   grant;
  logic [PE_IDX_W-1:0] grant_idx;
  logic                any_grant;
  logic                load;
  logic                accept;

  // A PE competes only while it is below its outstanding cap.
  always_comb begin
    eligible = '0;
    for (int i = 0; i < NUM_PE; i++) begin
      eligible[i] = pe_req_valid[i] && (cnt_q[i] < CNT_W'(MAX_OUTSTANDING));
    end
  end

  match_req_arbiter_rr #(
    .N  (NUM_PE),
    .IW (PE_IDX_W)
  ) u_rr (
    .req_i   (eligible),
    .ptr_i   (rr_ptr_q),
    .grant_o (grant),
    .idx_o   (grant_idx),
    .any_o   (any_grant)
  );

  assign load         = !req_valid_q || mu_req_ready;
  assign accept       = load && any_grant;
  assign pe_req_ready = {NUM_PE{load}} & grant;

  // Output slot: capture the winner when the slot can load, otherwise hold.
  always_comb begin
    req_valid_d = req_valid_q;
    head_d      = head_q;
    hist_d      = hist_q;
    tag_d       = tag_q;
    rr_ptr_d    = rr_ptr_q;
    if (load) begin
      req_valid_d = any_grant;
      if (any_grant) begin
        head_d = pe_req_head_addr[int'(grant_idx)*ADDR_WIDTH +: ADDR_WIDTH];
        hist_d = pe_req_history_addr[int'(grant_idx)*ADDR_WIDTH +: ADDR_WIDTH];
        tag_d  = {grant_idx,
                  pe_req_tag[int'(grant_idx)*MATCH_TAG_WIDTH +: MATCH_TAG_WIDTH]};
        rr_ptr_d = (grant_idx == PE_IDX_W'(NUM_PE - 1)) ? '0
                                                          : grant_idx + PE_IDX_W'(1);
      end
    end
  end

  assign mu_req_valid        = req_valid_q;
  assign mu_req_head_addr    = head_q;
  assign mu_req_history_addr = hist_q;
  assign mu_req_tag          = tag_q;

  // ---------------------------------------------------------------- response demux
  logic [PE_IDX_W-1:0] resp_idx;
  logic                resp_idx_legal;

  assign resp_idx = mu_resp_tag[TAG_W-1 -: PE_IDX_W];

  // With a power-of-two PE count every index decodes to a real PE.
  if (is_pow2(NUM_PE)) begin : g_idx_pow2
    assign resp_idx_legal = 1'b1;
  end else begin : g_idx_range
    assign resp_idx_legal = ({1'b0, resp_idx} < (PE_IDX_W + 1)'(NUM_PE));
  end

  // Steer the response to the tagged PE; an undecodable index is swallowed.
  always_comb begin
    pe_resp_valid = '0;
    mu_resp_ready = 1'b1;
    for (int k = 0; k < NUM_PE; k++) begin
      pe_resp_valid[k] = mu_resp_valid && resp_idx_legal && (resp_idx == PE_IDX_W'(k));
    end
    if (resp_idx_legal) begin
      mu_resp_ready = pe_resp_ready[resp_idx];
    end
  end

  assign pe_resp_tag = mu_resp_tag[MATCH_TAG_WIDTH-1:0];
  assign pe_resp_len = mu_resp_len;

  // ---------------------------------------------------------------- counters / error
  logic unsolicited;
  logic inc, dec;

  // Track in-flight requests per PE; a response with nothing outstanding is
  // flagged rather than wrapping the counter.
  always_comb begin
    unsolicited = 1'b0;
    inc         = 1'b0;
    dec         = 1'b0;
    for (int i = 0; i < NUM_PE; i++) begin
      cnt_d[i] = cnt_q[i];
      inc      = accept && grant[i];
      dec      = pe_resp_valid[i] && pe_resp_ready[i];
      if (inc && !dec) begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end else if (dec && !inc) begin
        if (cnt_q[i] == '0) begin
          unsolicited = 1'b1;
        end else begin
          cnt_d[i] = cnt_q[i] - CNT_W'(1);
        end
      end
    end
    err_d = err_q || unsolicited || (mu_resp_valid && !resp_idx_legal);
  end

  assign err = err_q;

  // Idle means nothing buffered and nothing owed back to any PE.
  always_comb begin
    idle = !req_valid_q;
    for (int i = 0; i < NUM_PE; i++) begin
      if (cnt_q[i] != '0) idle = 1'b0;
    end
  end

  // ---------------------------------------------------------------- registers
  // All state clears immediately on reset; payload needs no reset but is
  // cleared anyway so the outputs are never X.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_valid_q <= 1'b0;
      head_q      <= '0;
      hist_q      <= '0;
      tag_q       <= '0;
      rr_ptr_q    <= '0;
      err_q       <= 1'b0;
      for (int i = 0; i < NUM_PE; i++) cnt_q[i] <= '0;
    end else begin
      req_valid_q <= req_valid_d;
      head_q      <= head_d;
      hist_q      <= hist_d;
      tag_q       <= tag_d;
      rr_ptr_q    <= rr_ptr_d;
      err_q       <= err_d;
      for (int i = 0; i < NUM_PE; i++) cnt_q[i] <= cnt_d[i];
    end
  end

endmodule
